// File: rtl/ysyx_22041211_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the architectural PC, issues one AR/R
// read per instruction and hands the returned word to decode through a
// valid/ready handshake. Branch redirects that land while a read is in
// flight are remembered in a flush flag so the stale word is dropped.
module ysyx_22041211_fetch_ctrl #(
  parameter int                    ADDR_LEN  = 32,
  parameter int                    DATA_LEN  = 32,
  parameter logic [ADDR_LEN-1:0]   RESET_VAL = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  // read-address channel
  output logic [ADDR_LEN-1:0] ifu_araddr,
  output logic                ifu_arvalid,
  input  logic                ifu_arready,
  // read-data channel
  input  logic [DATA_LEN-1:0] ifu_rdata,
  input  logic [1:0]          ifu_rresp,
  input  logic                ifu_rvalid,
  output logic                ifu_rready,
  // decode interface
  output logic [DATA_LEN-1:0] inst_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  // redirect interface
  input  logic                branch_request_i,
  input  logic                branch_flag_i,
  input  logic [ADDR_LEN-1:0] branch_target_i,
  // status
  output logic [ADDR_LEN-1:0] pc,
  output logic                fetch_err_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] OUT  = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  localparam logic [ADDR_LEN-1:0] PC_STEP = ADDR_LEN'(32'd4);
  localparam logic [1:0]          RESP_OKAY = 2'b00;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic                flush;
  logic                next_flush;
  logic [ADDR_LEN-1:0] next_pc;
  logic [ADDR_LEN-1:0] next_araddr;
  logic [DATA_LEN-1:0] next_inst;
  logic                next_err;

  logic                redirect;
  logic [ADDR_LEN-1:0] target;
  logic [ADDR_LEN-1:0] pc_plus4;
  logic                bus_err;

  // Instructions are word aligned, so the low target bits are dropped.
  logic                unused_target_bits;

  assign redirect           = branch_request_i & branch_flag_i;
  assign target             = {branch_target_i[ADDR_LEN-1:2], 2'b00};
  assign pc_plus4           = pc + PC_STEP;
  assign bus_err            = (ifu_rresp != RESP_OKAY);
  assign unused_target_bits = ^branch_target_i[1:0];

  // Next-state, next-PC and datapath decisions for every fetch state.
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    next_araddr = ifu_araddr;
    next_flush  = flush;
    next_inst   = inst_o;
    next_err    = fetch_err_o;

    case (state)
      IDLE: begin
        // First cycle after reset: latch the address that AR will present.
        if (redirect) begin
          next_pc = target;
        end else begin
          next_pc = pc;
        end
        next_araddr = next_pc;
        next_state  = AR;
      end

      AR: begin
        // The presented address is held until arready even if pc moves;
        // a redirect here only retargets pc and marks the fetch stale.
        if (redirect) begin
          next_pc    = target;
          next_flush = 1'b1;
        end else begin
          next_pc    = pc;
        end
        if (ifu_arready) begin
          next_state = R;
        end else begin
          next_state = AR;
        end
      end

      R: begin
        if (ifu_rvalid) begin
          if (bus_err) begin
            next_err   = 1'b1;
            next_state = HALT;
          end else if (flush || redirect) begin
            // Stale word: drop it and refetch from the (possibly new) pc.
            next_flush = 1'b0;
            if (redirect) begin
              next_pc = target;
            end else begin
              next_pc = pc;
            end
            next_araddr = next_pc;
            next_state  = AR;
          end else begin
            next_inst  = ifu_rdata;
            next_state = OUT;
          end
        end else if (redirect) begin
          next_pc    = target;
          next_flush = 1'b1;
        end else begin
          next_state = R;
        end
      end

      OUT: begin
        if (inst_ready_i) begin
          if (redirect) begin
            next_pc = target;
          end else begin
            next_pc = pc_plus4;
          end
          next_araddr = next_pc;
          next_state  = AR;
        end else if (redirect) begin
          // Decode has not taken the word and the path changed: drop it.
          next_pc     = target;
          next_araddr = target;
          next_state  = AR;
        end else begin
          next_state = OUT;
        end
      end

      HALT: begin
        next_err   = 1'b1;
        next_state = HALT;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and registered outputs; valids are derived from the next state
  // so no ready input ever reaches a valid output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_VAL;
      ifu_araddr   <= RESET_VAL;
      flush        <= 1'b0;
      inst_o       <= {DATA_LEN{1'b0}};
      fetch_err_o  <= 1'b0;
      ifu_arvalid  <= 1'b0;
      ifu_rready   <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      state        <= next_state;
      pc           <= next_pc;
      ifu_araddr   <= next_araddr;
      flush        <= next_flush;
      inst_o       <= next_inst;
      fetch_err_o  <= next_err;
      ifu_arvalid  <= (next_state == AR);
      ifu_rready   <= (next_state == R);
      inst_valid_o <= (next_state == OUT);
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_fetch_ctrl.sv
// Directed bench for the fetch sequencer: one task per scenario, each
// driving the bus/decode side cycle by cycle and checking inline.
module tb_ysyx_22041211_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        branch_request_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc;
  logic        fetch_err_o;

  int tests;
  int fails;

  ysyx_22041211_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_araddr       (ifu_araddr),
    .ifu_arvalid      (ifu_arvalid),
    .ifu_arready      (ifu_arready),
    .ifu_rdata        (ifu_rdata),
    .ifu_rresp        (ifu_rresp),
    .ifu_rvalid       (ifu_rvalid),
    .ifu_rready       (ifu_rready),
    .inst_o           (inst_o),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .branch_request_i (branch_request_i),
    .branch_flag_i    (branch_flag_i),
    .branch_target_i  (branch_target_i),
    .pc               (pc),
    .fetch_err_o      (fetch_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From AR: zero-wait address handshake, then return one OKAY word.
  task automatic do_fetch(input logic [31:0] data);
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b1;
    ifu_rdata   = data;
    ifu_rresp   = 2'b00;
    step();
    ifu_rvalid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_arready = 1'b0; ifu_rdata = 32'h0; ifu_rresp = 2'b00; ifu_rvalid = 1'b0;
    inst_ready_i = 1'b0; branch_request_i = 1'b0; branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    repeat (3) step();
    tests++;
    if (pc !== 32'h8000_0000) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h8000_0000); end
    tests++;
    if ({ifu_arvalid, ifu_rready, inst_valid_o, fetch_err_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {ifu_arvalid, ifu_rready, inst_valid_o, fetch_err_o});
    end
    tests++;
    if (inst_o !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 0", inst_o); end
    rst = 1'b0;
    // IDLE for one cycle, then AR.
    step();
    tests++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h8000_0000) begin
      fails++; $display("FAIL first_ar: got v=%b a=%h expected v=1 a=80000000", ifu_arvalid, ifu_araddr);
    end
  endtask

  task automatic test_basic_fetch_backpressure();
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    tests++;
    if (ifu_rready !== 1'b1 || ifu_arvalid !== 1'b0) begin
      fails++; $display("FAIL r_state: got rready=%b arvalid=%b expected 1 0", ifu_rready, ifu_arvalid);
    end
    ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_0413; ifu_rresp = 2'b00;
    step();
    ifu_rvalid = 1'b0;
    tests++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0413 || pc !== 32'h8000_0000) begin
      fails++; $display("FAIL first_out: got v=%b inst=%h pc=%h expected 1 00000413 80000000", inst_valid_o, inst_o, pc);
    end
    // Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0413 || pc !== 32'h8000_0000 || ifu_arvalid !== 1'b0) begin
        fails++; $display("FAIL stall_%0d: got v=%b inst=%h pc=%h arv=%b expected 1 00000413 80000000 0", i, inst_valid_o, inst_o, pc, ifu_arvalid);
      end
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    tests++;
    if (pc !== 32'h8000_0004 || ifu_araddr !== 32'h8000_0004 || ifu_arvalid !== 1'b1 || inst_valid_o !== 1'b0) begin
      fails++; $display("FAIL advance: got pc=%h a=%h arv=%b v=%b expected 80000004 80000004 1 0", pc, ifu_araddr, ifu_arvalid, inst_valid_o);
    end
  endtask

  task automatic test_branch_handshake();
    do_fetch(32'h0000_0011);
    inst_ready_i = 1'b1; branch_request_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h8000_0103;
    step();
    inst_ready_i = 1'b0; branch_request_i = 1'b0; branch_flag_i = 1'b0;
    tests++;
    if (ifu_araddr !== 32'h8000_0100 || pc !== 32'h8000_0100 || ifu_arvalid !== 1'b1) begin
      fails++; $display("FAIL taken_branch: got a=%h pc=%h arv=%b expected 80000100 80000100 1", ifu_araddr, pc, ifu_arvalid);
    end
    // Request without the taken flag falls through to pc+4.
    do_fetch(32'h0000_0022);
    inst_ready_i = 1'b1; branch_request_i = 1'b1; branch_flag_i = 1'b0; branch_target_i = 32'h8000_0500;
    step();
    inst_ready_i = 1'b0; branch_request_i = 1'b0;
    tests++;
    if (ifu_araddr !== 32'h8000_0104) begin
      fails++; $display("FAIL not_taken: got %h expected 80000104", ifu_araddr);
    end
    // Redirect while decode stalls: word is dropped and fetch retargets.
    do_fetch(32'h0000_0033);
    branch_request_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h8000_0200;
    step();
    branch_request_i = 1'b0; branch_flag_i = 1'b0;
    tests++;
    if (inst_valid_o !== 1'b0 || ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h8000_0200) begin
      fails++; $display("FAIL out_redirect: got v=%b arv=%b a=%h expected 0 1 80000200", inst_valid_o, ifu_arvalid, ifu_araddr);
    end
  endtask

  task automatic test_flush();
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    branch_request_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h8000_1000;
    step();
    branch_request_i = 1'b0; branch_flag_i = 1'b0;
    tests++;
    if (pc !== 32'h8000_1000 || ifu_rready !== 1'b1) begin
      fails++; $display("FAIL flush_pc: got pc=%h rready=%b expected 80001000 1", pc, ifu_rready);
    end
    for (int i = 0; i < 3; i++) step();
    ifu_rvalid = 1'b1; ifu_rdata = 32'hDEAD_BEEF; ifu_rresp = 2'b00;
    step();
    ifu_rvalid = 1'b0;
    tests++;
    if (inst_valid_o !== 1'b0 || ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h8000_1000) begin
      fails++; $display("FAIL flush_drop: got v=%b arv=%b a=%h expected 0 1 80001000", inst_valid_o, ifu_arvalid, ifu_araddr);
    end
    do_fetch(32'h0000_0044);
    tests++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0044 || pc !== 32'h8000_1000) begin
      fails++; $display("FAIL flush_refetch: got v=%b inst=%h pc=%h expected 1 00000044 80001000", inst_valid_o, inst_o, pc);
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    // Redirect in AR: presented address must hold, pc retargets.
    branch_request_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h8000_2002;
    step();
    branch_request_i = 1'b0; branch_flag_i = 1'b0;
    tests++;
    if (ifu_araddr !== 32'h8000_1004 || ifu_arvalid !== 1'b1 || pc !== 32'h8000_2000) begin
      fails++; $display("FAIL ar_redirect: got a=%h arv=%b pc=%h expected 80001004 1 80002000", ifu_araddr, ifu_arvalid, pc);
    end
    do_fetch(32'h0000_0055);
    tests++;
    if (inst_valid_o !== 1'b0 || ifu_araddr !== 32'h8000_2000 || ifu_arvalid !== 1'b1) begin
      fails++; $display("FAIL ar_flush: got v=%b a=%h arv=%b expected 0 80002000 1", inst_valid_o, ifu_araddr, ifu_arvalid);
    end
  endtask

  task automatic test_wrap();
    do_fetch(32'h0000_0066);
    inst_ready_i = 1'b1; branch_request_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    step();
    inst_ready_i = 1'b0; branch_request_i = 1'b0; branch_flag_i = 1'b0;
    do_fetch(32'h0000_0077);
    tests++;
    if (pc !== 32'hFFFF_FFFC || inst_o !== 32'h0000_0077) begin
      fails++; $display("FAIL wrap_pre: got pc=%h inst=%h expected fffffffc 00000077", pc, inst_o);
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    tests++;
    if (pc !== 32'h0000_0000 || ifu_araddr !== 32'h0000_0000) begin
      fails++; $display("FAIL wrap: got pc=%h a=%h expected 0 0", pc, ifu_araddr);
    end
  endtask

  task automatic test_bus_error();
    ifu_arready = 1'b1;
    step();
    ifu_rvalid = 1'b1; ifu_rresp = 2'b10; ifu_rdata = 32'h0000_0088;
    step();
    ifu_rvalid = 1'b0; ifu_rresp = 2'b00;
    tests++;
    if (fetch_err_o !== 1'b1 || ifu_rready !== 1'b0 || ifu_arvalid !== 1'b0 || inst_valid_o !== 1'b0) begin
      fails++; $display("FAIL bus_err: got err=%b rr=%b arv=%b v=%b expected 1 0 0 0", fetch_err_o, ifu_rready, ifu_arvalid, inst_valid_o);
    end
    inst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (ifu_arvalid !== 1'b0 || fetch_err_o !== 1'b1 || pc !== 32'h0000_0000) begin
        fails++; $display("FAIL halt_%0d: got arv=%b err=%b pc=%h expected 0 1 0", i, ifu_arvalid, fetch_err_o, pc);
      end
    end
    inst_ready_i = 1'b0; ifu_arready = 1'b0;
    // Asynchronous reset releases HALT.
    #2 rst = 1'b1;
    #1;
    tests++;
    if (fetch_err_o !== 1'b0 || pc !== 32'h8000_0000 || ifu_arvalid !== 1'b0) begin
      fails++; $display("FAIL err_reset: got err=%b pc=%h arv=%b expected 0 80000000 0", fetch_err_o, pc, ifu_arvalid);
    end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h8000_0000) begin
      fails++; $display("FAIL err_restart: got arv=%b a=%h expected 1 80000000", ifu_arvalid, ifu_araddr);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_fetch_backpressure();
    test_branch_handshake();
    test_flush();
    test_wrap();
    test_bus_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_fetch_ctrl.md
Name: ysyx_22041211_fetch_ctrl

Overview:
Multi-cycle instruction-fetch sequencer that owns the architectural PC. It issues one read per instruction on an AXI-lite-style read channel (AR/R) and presents the returned word to decode with a valid/ready handshake. It advances PC by 4 or redirects to a branch target. A redirect that arrives mid-fetch flushes the stale fetch. It replaces free-running PC update with a per-instruction sequenced update, so the core tolerates variable memory latency.

Parameters:
ADDR_LEN, 32, PC/address width
DATA_LEN, 32, instruction word width
RESET_VAL, 32'h8000_0000, PC value after reset

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous reset, active-high
ifu_araddr  out  ADDR_LEN  fetch address, equals pc
ifu_arvalid  out  1  read-address valid
ifu_arready  in  1  read-address ready
ifu_rdata  in  DATA_LEN  read data
ifu_rresp  in  2  read response, 2'b00 = OKAY
ifu_rvalid  in  1  read-data valid
ifu_rready  out  1  read-data ready
inst_o  out  DATA_LEN  fetched instruction to decode
inst_valid_o  out  1  inst_o valid
inst_ready_i  in  1  decode accepts inst_o
branch_request_i  in  1  branch/jump resolved this cycle
branch_flag_i  in  1  branch taken
branch_target_i  in  ADDR_LEN  redirect target
pc  out  ADDR_LEN  current PC, the address of inst_o when inst_valid_o is high
fetch_err_o  out  1  sticky bus-error flag

Behaviour:
- Reset, asynchronous: pc=RESET_VAL, state=IDLE, ifu_arvalid=0, ifu_rready=0, inst_valid_o=0, inst_o=0, fetch_err_o=0, flush=0.
- redirect = branch_request_i & branch_flag_i. Effective target = {branch_target_i[ADDR_LEN-1:2], 2'b00}.
- States: IDLE, AR, R, OUT, HALT. Outputs are registered or decoded from state only. No combinational path from the ready inputs to the valid outputs.
- IDLE: one cycle after reset release, then go to AR.
- AR:
  - ifu_arvalid=1, ifu_araddr=pc.
  - Address and valid stay stable until ifu_arready=1. On the handshake, go to R.
- R:
  - ifu_rready=1.
  - On ifu_rvalid with ifu_rresp≠0: fetch_err_o<=1, go to HALT.
  - On ifu_rvalid with OKAY and flush=0: inst_o<=ifu_rdata, go to OUT.
  - On ifu_rvalid with OKAY and flush=1: discard data, flush<=0, go to AR (pc already holds the target).
- OUT:
  - inst_valid_o=1. inst_o and pc are stable until the handshake.
  - On inst_ready_i=1: pc <= redirect ? target : pc+4, with modulo 2^ADDR_LEN wrap. Go to AR.
  - On redirect with inst_ready_i=0: drop inst_valid_o, pc<=target, go to AR.
- Redirect during AR or R:
  - pc<=target immediately and flush<=1.
  - The outstanding transaction always completes. It is never aborted and ifu_araddr is not changed mid-handshake. In AR, the address already presented stays until arready.
  - Redirect in the same cycle as the AR handshake: flush<=1, and pc takes the target.
  - A later redirect before the flush resolves overwrites pc; flush stays set.
- Redirect and ifu_rvalid in the same cycle in R: the data is discarded, state goes to AR, and pc takes the new target.
- HALT: all valids low, fetch_err_o=1, pc frozen. Exit only through rst.
- Minimum latency with zero-wait memory (arready=1, rvalid the cycle after AR): AR→R→OUT. inst_valid_o rises 2 cycles after AR entry. Steady-state throughput is 1 instruction per 3 cycles.
- Reset mid-operation returns to the reset values immediately. Any later bus response is ignored, because rready=0.

Test Plan:
- Reset sequence: hold rst, release; arready=1, rvalid next cycle with rdata=32'h00000413, inst_ready=1 → araddr=0x80000000; inst_o=0x00000413 valid 2 cycles after AR; next araddr=0x80000004.
- Backpressure: inst_ready=0 for 5 cycles in OUT → inst_o and pc stable, no new arvalid; on ready, pc=0x80000004.
- Taken branch at handshake: redirect with target 0x80000103 on the inst_ready cycle → next araddr=0x80000100. With branch_flag_i=0 in the same setup → next araddr=pc+4.
- Flush: redirect target 0x80001000 while in R with rvalid delayed 4 cycles → returned data never appears on inst_valid_o; next araddr=0x80001000; inst_valid_o asserted only for the new fetch.
- Bus error and wrap: rresp=2'b10 → fetch_err_o=1, HALT, no further arvalid until rst. Separately, pc=0xFFFFFFFC plus handshake without redirect → pc=0x00000000.
